btn_conditioner: RTL

//  Front-end for the calculator push-buttons: synchronises, debounces and edge-detects btns[N_BTN-1:0].

---
 rtl/btn_conditioner.sv | 137 +++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button synchroniser, debouncer and single-press pulse interlock
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat pulses while the owning button is held)
module btn_conditioner #(
  parameter int N_BTN      = 5,
  parameter int DB_CYCLES  = 1000000,
  parameter int CNT_W      = 20,
  parameter int RPT_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btns,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic             any_held
);

  if (DB_CYCLES < 1 || (64'(1) << CNT_W) < 64'(DB_CYCLES)) begin : g_bad_db
    $error("btn_conditioner: CNT_W too small for DB_CYCLES");
  end
  if (RPT_CYCLES < 1) begin : g_bad_rpt
    $error("btn_conditioner: RPT_CYCLES must be at least 1");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } press_state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [CNT_W-1:0] cnt     [N_BTN];
  logic [CNT_W-1:0] cnt_nxt [N_BTN];
  press_state_t     state   [N_BTN];

  logic [N_BTN-1:0] level_nxt;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] press_pulse;
  logic [N_BTN-1:0] pulse_nxt;

  always_comb begin
    level_nxt   = btn_level;
    rise        = '0;
    press_pulse = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != btn_level[i]) begin
        if (cnt[i] == DB_LAST) begin
          level_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
      rise[i] = (state[i] == RELEASED) && level_nxt[i];
    end
    // Only a press onto an idle keypad pulses; ties go to the lowest index.
    if (btn_level == '0) begin
      press_pulse = rise & (~rise + N_BTN'(1));
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(RPT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(RPT_CYCLES - 1);

  logic [N_BTN-1:0] owner;
  logic [N_BTN-1:0] owner_nxt;
  logic [RPT_W-1:0] rcnt     [N_BTN];
  logic [RPT_W-1:0] rcnt_nxt [N_BTN];
  logic [N_BTN-1:0] rpt_pulse;

  // Ownership is taken only by the button that pulsed, so repeats stay one-hot.
  always_comb begin
    owner_nxt = (owner | press_pulse) & level_nxt;
    rpt_pulse = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rcnt_nxt[i] = '0;
      if (owner[i] && level_nxt[i]) begin
        if (rcnt[i] == RPT_LAST) begin
          rpt_pulse[i] = 1'b1;
        end else begin
          rcnt_nxt[i] = rcnt[i] + 1'b1;
        end
      end
    end
    pulse_nxt = press_pulse | rpt_pulse;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        rcnt[i] <= '0;
      end
    end else begin
      owner <= owner_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        rcnt[i] <= rcnt_nxt[i];
      end
    end
  end
`else
  always_comb begin
    pulse_nxt = press_pulse;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      btn_level <= '0;
      btn_pulse <= '0;
      any_held  <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i]   <= '0;
        state[i] <= RELEASED;
      end
    end else begin
      sync1     <= btns;
      sync2     <= sync1;
      btn_level <= level_nxt;
      btn_pulse <= pulse_nxt;
      any_held  <= |level_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= cnt_nxt[i];
        case (state[i])
          RELEASED: if (level_nxt[i])  state[i] <= PRESSED;
          PRESSED:  if (!level_nxt[i]) state[i] <= RELEASED;
          default:  state[i] <= RELEASED;
        endcase
      end
    end
  end

endmodule
